// File: rtl/serial_pkg.sv
// serial_pkg -- shared definitions for the serial frame transmitter.
//
// Contents:
//   state_t               FSM state encoding (IDLE=0, START=1, DATA=2,
//                         PARITY=3, STOP=4), 3 bits wide
//   IDLE_LEVEL            line level while nothing is being sent (1)
//   START_LEVEL           level of the start bit (0)
//   STOP_LEVEL            level of the stop bit (1)
//   DEFAULT_CLKS_PER_BIT  default number of clocks each serial bit is held
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

    localparam int DEFAULT_CLKS_PER_BIT = 4;

endpackage

// File: rtl/serial_bit_timer.sv
// serial_bit_timer -- per-bit duration timer for the serial transmitter.
//
// Counts 0..CLKS_PER_BIT-1 and raises tick during the terminal count, so
// one serial bit lasts exactly CLKS_PER_BIT clocks. With CLKS_PER_BIT=1
// tick is high every cycle.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>=1)
// Ports:
//   clk      input   rising-edge clock
//   rst_n    input   asynchronous active-low reset, clears the counter
//   restart  input   force the counter back to 0 on the next edge
//   tick     output  high during the last cycle of the current bit
module serial_bit_timer #(
    parameter int CLKS_PER_BIT = serial_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/serial_tx.sv
// serial_tx -- parallel-to-serial frame transmitter.
//
// Accepts a DATA_W-bit word over a valid/ready handshake and sends it
// LSB-first as: start bit (0), data bits, optional parity, stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. After the stop bit the FSM
// spends one cycle in IDLE before it can start the next frame.
//
// Build option:
//   SERIAL_TX_PARITY_EN  when defined, an even-parity bit (XOR of the word,
//                        captured at accept) is sent between the data bits
//                        and the stop bit.
//
// Parameters:
//   DATA_W        data bits per frame (>=1)
//   CLKS_PER_BIT  clock cycles each serial bit is held (>=1)
// Ports:
//   clk       input   rising-edge clock
//   rst_n     input   asynchronous active-low reset
//   tx_data   input   word to transmit, sampled only on accept
//   tx_valid  input   source has a word
//   tx_ready  output  transmitter can accept a word this cycle
//   tx_out    output  registered serial line, idles high
//   tx_busy   output  frame in progress (state other than IDLE)
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = serial_pkg::DEFAULT_CLKS_PER_BIT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_out,
    output logic              tx_busy
);

    import serial_pkg::*;

    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

    state_t            state;
    state_t            state_d;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_d;
    logic [BW-1:0]     bit_cnt;
    logic [BW-1:0]     bit_cnt_d;
    logic              out_d;
    logic              ready_d;
    logic              accept;
    logic              tick;
    logic              restart;
`ifdef SERIAL_TX_PARITY_EN
    logic              par_q;
    logic              par_d;
`endif

    // tx_ready is only ever high in IDLE, so this is the handshake.
    assign accept = tx_valid && tx_ready;

    // Hold the timer at zero in IDLE and on every state change so each
    // state starts with a full bit period.
    assign restart = (state == IDLE) || (state_d != state);

    serial_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .restart(restart),
        .tick   (tick)
    );

    always_comb begin
        state_d   = state;
        shreg_d   = shreg;
        bit_cnt_d = bit_cnt;
`ifdef SERIAL_TX_PARITY_EN
        par_d     = par_q;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d   = START;
                    shreg_d   = tx_data;
                    bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                    par_d     = ^tx_data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        shreg_d   = shreg >> 1;
                        bit_cnt_d = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The line level is derived from the next state so the registered
        // tx_out changes on the same edge as the state register.
        out_d = IDLE_LEVEL;
        case (state_d)
            IDLE:    out_d = IDLE_LEVEL;
            START:   out_d = START_LEVEL;
            DATA:    out_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  out_d = par_d;
`endif
            STOP:    out_d = STOP_LEVEL;
            default: out_d = IDLE_LEVEL;
        endcase

        ready_d = (state_d == IDLE);
    end

    // tx_ready is a flop reset to 0 so it only rises on the first edge
    // after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            tx_out   <= IDLE_LEVEL;
            tx_ready <= 1'b0;
        end else begin
            state    <= state_d;
            shreg    <= shreg_d;
            bit_cnt  <= bit_cnt_d;
            tx_out   <= out_d;
            tx_ready <= ready_d;
        end
    end

`ifdef SERIAL_TX_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

    assign tx_busy = (state != IDLE);

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx -- self-checking bench for serial_tx.
//
// Two instances: dut with CLKS_PER_BIT=4 and dut1 with CLKS_PER_BIT=1,
// both DATA_W=8. Expected frames are queued when a word is offered; one
// monitor per instance detects each start bit, pops the expected frame and
// checks every cycle of every bit. Honours SERIAL_TX_PARITY_EN.
module tb_serial_tx;

`ifdef SERIAL_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    localparam int FRAME0 = (8 + 2 + PBITS) * 4;

    typedef struct {
        logic [10:0] bits;
        int          n;
    } frame_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] tx_data,  tx_data1;
    logic       tx_valid, tx_valid1;
    logic       tx_ready, tx_ready1;
    logic       tx_out,   tx_out1;
    logic       tx_busy,  tx_busy1;

    frame_t expQ0[$];
    frame_t expQ1[$];
    int     compCnt    = 0;
    int     failCnt    = 0;
    int     done[2]    = '{0, 0};
    int     abortCnt   = 0;
    int     cyc        = 0;
    int     startPrev0 = 0;
    int     startLast0 = 0;
    int     lowRun     = 0;
    int     lastLowRun = 0;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_out  (tx_out),
        .tx_busy (tx_busy)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_data (tx_data1),
        .tx_valid(tx_valid1),
        .tx_ready(tx_ready1),
        .tx_out  (tx_out1),
        .tx_busy (tx_busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Length of each tx_ready-low stretch while a frame is in progress.
    always @(negedge clk) begin
        if (!rst_n) begin
            lowRun = 0;
        end else if (!tx_ready && tx_busy) begin
            lowRun++;
        end else if (tx_ready && lowRun != 0) begin
            lastLowRun = lowRun;
            lowRun = 0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compCnt++;
        if (actual !== expected) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Expected line sequence in time order: start, data LSB first,
    // optional parity (hand-computed by the caller), stop.
    function automatic frame_t mkFrame(input logic [7:0] word, input logic par);
        frame_t f;
        f.bits = '0;
        f.bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) f.bits[1+i] = word[i];
        if (PBITS != 0) f.bits[9] = par;
        f.bits[9+PBITS] = 1'b1;
        f.n = 10 + PBITS;
        return f;
    endfunction

    task automatic pushExp(input int which, input logic [7:0] word, input logic par);
        if (which == 0) expQ0.push_back(mkFrame(word, par));
        else            expQ1.push_back(mkFrame(word, par));
    endtask

    task automatic runMonitor(input int which);
        frame_t e;
        int     cpb;
        logic   line;
        logic   seen;
        logic   aborted;
        int     qsize;
        cpb = (which == 0) ? 4 : 1;
        forever begin
            @(negedge clk);
            line = (which == 0) ? tx_out : tx_out1;
            if (rst_n && line === 1'b0) begin
                if (which == 0) begin
                    startPrev0 = startLast0;
                    startLast0 = cyc;
                end
                qsize = (which == 0) ? expQ0.size() : expQ1.size();
                checkOutput($sformatf("dut%0d frame expected", which), {31'b0, qsize > 0}, 1);
                if (qsize > 0) begin
                    if (which == 0) e = expQ0.pop_front();
                    else            e = expQ1.pop_front();
                    aborted = 1'b0;
                    for (int k = 0; k < e.n && !aborted; k++) begin
                        seen = 1'bz;
                        for (int c = 0; c < cpb && !aborted; c++) begin
                            if (k != 0 || c != 0) @(negedge clk);
                            line = (which == 0) ? tx_out : tx_out1;
                            if (!rst_n) aborted = 1'b1;
                            else if (c == 0) seen = line;
                            else if (line !== seen) seen = 1'bx;
                        end
                        if (!aborted)
                            checkOutput($sformatf("dut%0d bit %0d", which, k), {31'b0, seen}, {31'b0, e.bits[k]});
                    end
                    if (aborted) abortCnt++;
                    else         done[which]++;
                end
            end
        end
    endtask

    initial runMonitor(0);
    initial runMonitor(1);

    task automatic waitDone(input int which, input int target, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done[which] >= target) break;
            @(posedge clk);
        end
        checkOutput($sformatf("dut%0d frames completed", which), done[which], target);
    endtask

    // Offer one word; returns #1 after the accept edge with tx_valid still
    // high when hold is set.
    task automatic applyStimulus(input int which, input logic [7:0] word,
                                 input logic par, input bit hold);
        logic rdy;
        rdy = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rdy = (which == 0) ? tx_ready : tx_ready1;
            if (rdy) break;
        end
        checkOutput($sformatf("dut%0d ready before %02h", which, word), {31'b0, rdy}, 1);
        pushExp(which, word, par);
        if (which == 0) begin tx_data = word;  tx_valid = 1'b1;  end
        else            begin tx_data1 = word; tx_valid1 = 1'b1; end
        @(posedge clk);
        #1;
        if (which == 0) begin
            checkOutput("accept line low", {31'b0, tx_out}, 0);
            checkOutput("accept ready low", {31'b0, tx_ready}, 0);
            checkOutput("accept busy", {31'b0, tx_busy}, 1);
            if (!hold) tx_valid = 1'b0;
        end else begin
            checkOutput("dut1 accept line low", {31'b0, tx_out1}, 0);
            if (!hold) tx_valid1 = 1'b0;
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n = 1'b0;
        tx_data = 8'h00;  tx_valid = 1'b0;
        tx_data1 = 8'h00; tx_valid1 = 1'b0;

        // Reset state, with a clock edge inside reset.
        #12;
        checkOutput("reset tx_out", {31'b0, tx_out}, 1);
        checkOutput("reset tx_ready", {31'b0, tx_ready}, 0);
        checkOutput("reset tx_busy", {31'b0, tx_busy}, 0);
        checkOutput("reset dut1 tx_out", {31'b0, tx_out1}, 1);
        checkOutput("reset dut1 tx_ready", {31'b0, tx_ready1}, 0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready after release", {31'b0, tx_ready}, 1);
        checkOutput("dut1 ready after release", {31'b0, tx_ready1}, 1);

        // 0xA5: four 1s, even parity 0.
        applyStimulus(0, 8'hA5, 1'b0, 0);
        waitDone(0, 1, 200);
        repeat (2) @(posedge clk);
        checkOutput("ready low run A5", lastLowRun, FRAME0);

        // 0x01: one 1, parity 1.
        applyStimulus(0, 8'h01, 1'b1, 0);
        waitDone(0, 2, 200);
        repeat (2) @(posedge clk);
        checkOutput("ready low run 01", lastLowRun, FRAME0);

        // Back-to-back with tx_valid held: 0x00 then 0xFF (8 ones, parity 0).
        applyStimulus(0, 8'h00, 1'b0, 1);
        tx_data = 8'hFF;
        pushExp(0, 8'hFF, 1'b0);
        begin
            bit seenIdle;
            seenIdle = 0;
            for (int i = 0; i < 200; i++) begin
                @(posedge clk);
                #1;
                if (!tx_busy) seenIdle = 1;
                else if (seenIdle) break;
            end
        end
        tx_valid = 1'b0;
        waitDone(0, 4, 200);
        checkOutput("back-to-back start spacing", startLast0 - startPrev0, FRAME0 + 1);

        // 0xC3 (parity 0); data and valid change during the frame.
        applyStimulus(0, 8'hC3, 1'b0, 1);
        tx_data = 8'h3C;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        waitDone(0, 5, 200);

        // Abort a 0x96 frame at cycle 17 while bit 3 (a 0) is on the line.
        applyStimulus(0, 8'h96, 1'b0, 0);
        repeat (16) @(posedge clk);
        #2;
        checkOutput("line before abort", {31'b0, tx_out}, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("abort tx_out", {31'b0, tx_out}, 1);
        checkOutput("abort tx_busy", {31'b0, tx_busy}, 0);
        checkOutput("abort tx_ready", {31'b0, tx_ready}, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready after abort release", {31'b0, tx_ready}, 1);
        checkOutput("aborted frame count", abortCnt, 1);

        // Fresh 0x5A (four 1s, parity 0).
        applyStimulus(0, 8'h5A, 1'b0, 0);
        waitDone(0, 6, 200);

        // One clock per bit: 0x81 (two 1s, parity 0).
        applyStimulus(1, 8'h81, 1'b0, 0);
        waitDone(1, 1, 100);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("dut1 idle after frame", {31'b0, tx_busy1}, 0);

        checkOutput("dut queue drained", expQ0.size(), 0);
        checkOutput("dut1 queue drained", expQ1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
- Parallel-to-serial frame transmitter that produces the single-bit serial data line sampled by the team's D flip-flop capture stages.
- Accepts a DATA_W-bit word over a valid/ready handshake and shifts it out LSB-first as: start bit (0), data bits, optional parity, stop bit (1).
- Each bit is held for CLKS_PER_BIT clock cycles.
- Sits between a word-producing source and a downstream serial receiver.

Parameters:
- DATA_W, 8, data bits per frame (>=1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- tx_data  input  DATA_W  word to transmit; sampled only on accept.
- tx_valid  input  1  source has a word.
- tx_ready  output  1  transmitter can accept a word this cycle.
- tx_out  output  1  serial line, registered, idles high.
- tx_busy  output  1  frame in progress (any state other than IDLE).

Behaviour:
- Clocking and reset:
  - One clock. Reset is asynchronous, active-low (rst_n).
  - While rst_n=0: tx_out=1, tx_ready=0, tx_busy=0, state=IDLE, all counters and the shift register cleared.
  - Asserting rst_n mid-frame aborts the frame immediately; tx_out goes high asynchronously.
  - tx_ready rises on the first clk edge after release.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP.
- IDLE: tx_out=1, tx_ready=1. A handshake occurs when tx_valid && tx_ready at a rising edge; tx_data is latched into the shift register and the FSM moves to START.
- START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - tx_out = shift register bit 0, held CLKS_PER_BIT cycles; then shift right.
  - Bit counter (width $clog2(DATA_W), minimum 1) increments.
  - After DATA_W bits, go to PARITY or STOP.
- STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE.
- Latency: tx_out falls on the edge following the accept edge.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT with parity.
- Back-to-back frames: after STOP the FSM spends exactly one cycle in IDLE (line high), so frames are separated by the stop bit plus 1 cycle.
- tx_ready=0 in every state except IDLE. tx_busy is the inverse of the IDLE state (0 during reset).
- tx_data and tx_valid changes during a frame have no effect.
- Bit timer:
  - Counts 0..CLKS_PER_BIT-1; issues a tick on the terminal count; reloads 0 on every state entry.
  - CLKS_PER_BIT=1: tick every cycle, each bit lasts exactly 1 cycle.
- tx_out is driven from a flop, never combinationally from state.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP.
  - tx_out = even parity, i.e. XOR of the latched word, computed at accept and stored.
  - Held CLKS_PER_BIT cycles.
- Undefined: no PARITY state, no parity register; DATA goes directly to STOP.

Decomposition:
- Shared package serial_pkg:
  - State typedef and encodings (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4), 3-bit.
  - Constants: idle line level (1), start level (0), stop level (1).
  - Default CLKS_PER_BIT.
- One sub-module, serial_bit_timer:
  - Parameter CLKS_PER_BIT.
  - Inputs clk, rst_n, restart.
  - Output tick.

Test Plan (DATA_W=8, CLKS_PER_BIT=4 unless noted):
- Send 0xA5:
  - tx_out = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - tx_ready low for 40 cycles, first low at the edge after accept.
- With SERIAL_TX_PARITY_EN, send 0xA5 then 0x01:
  - Parity bits 0 then 1.
  - Frames 44 cycles each.
- tx_valid held high with 0x00 then 0xFF:
  - Two frames with exactly one idle-high cycle between the 0x00 stop bit and the 0xFF start bit.
  - Second word captured correctly.
- Change tx_data to 0x3C and drop tx_valid two cycles into a 0xC3 frame: serialized bits still match 0xC3.
- Pull rst_n low at cycle 17 of a frame: tx_out=1 immediately with no clock edge.
  - After release, tx_ready=1 on the next edge and a fresh 0x5A frame is correct.
- CLKS_PER_BIT=1, send 0x81: tx_out = 0,1,0,0,0,0,0,0,1,1 over 10 consecutive cycles.
